thresholding_axilite_loader: RTL and testbench
==============================================

// Module: thresholding_axilite_loader
// PURPOSE
// - AXI-Lite initiator that loads a thresholding kernel's threshold memory at run time. Drives the kernel's s_axilite write port.
// - Takes threshold words from an AXI stream in FINN channel order and turns each into one AXI-Lite write.
// - Maps channel/threshold index to the aligned byte address: byte = {cf, pe, t, 2'b00}.
// - Sits between a DMA/parameter stream and one thresholding instance. Shares its clock/reset domain.
// PARAMETERS
// - O_WIDTH    2   output precision; thresholds per channel N_T = 2**O_WIDTH-1; t field width O_WIDTH
// - T_WIDTH    8   threshold precision (<=32)
// - CHANNELS   4   total channels; CHANNELS % PE == 0
// - PE         1   kernel parallelism; CF = CHANNELS/PE
// - T_SIGNED   1   sign-extend thresholds into WDATA (else zero-extend)
// - ADDR_BITS  localparam = $clog2(CF)+$clog2(PE)+O_WIDTH+2
// PORTS
// - ap_clk              in   1               clock, all logic on rising edge
// - ap_rst              in   1               async active-high reset
// - start               in   1               pulse; begins a full load when idle
// - busy                out  1               load in progress
// - done                out  1               one-cycle pulse at end of load
// - err                 out  1               sticky; set on non-OKAY BRESP (or mismatch); cleared by start
// - err_addr            out  ADDR_BITS       byte address of first failing access
// - s_thr_tvalid/tready in/out 1             threshold stream handshake
// - s_thr_tdata         in   ((T_WIDTH+7)/8)*8  threshold word in [T_WIDTH-1:0]
// - m_axilite_AWVALID/AWREADY/AWADDR  out/in/out 1/1/ADDR_BITS   write address
// - m_axilite_WVALID/WREADY  out/in 1        write data handshake
// - m_axilite_WDATA     out  32              extended threshold
// - m_axilite_WSTRB     out  4               always 4'hF
// - m_axilite_BVALID/BREADY/BRESP  in/out/in 1/1/2   write response
// - m_axilite_ARVALID/ARREADY/ARADDR, RVALID/RREADY/RDATA/RRESP   read channels (verify only)
// BEHAVIOUR
// - Reset: all VALID/READY outputs 0, busy=0, done=0, err=0, err_addr=0, counters 0, FSM IDLE.
// - Order: word k -> ch = k / N_T, t = k % N_T; pe = ch % PE, cf = ch / PE.
// - AWADDR = {cf, pe, t, 2'b00}. Counters: t wraps N_T-1 -> 0 and advances pe; pe wraps PE-1 -> 0 and advances cf.
// - States and transitions:
//   - IDLE: start -> FETCH. start while busy is ignored.
//   - FETCH: s_thr_tready=1. On handshake, latch data/addr -> ISSUE (tready=1 for one cycle only).
//   - ISSUE: AWVALID and WVALID asserted in the same cycle. Each channel drops independently on its own READY; if AW and W are accepted in different cycles, only the one not yet accepted stays asserted. After both accepted -> RESP.
//   - RESP: BREADY=1. On BVALID:
//     - BRESP!=0: set err, capture err_addr, abort -> DONE.
//     - OK and last word (k = CHANNELS*N_T-1) -> DONE.
//     - OK, otherwise -> FETCH.
//   - DONE: done=1 for one cycle -> IDLE. busy=1 in all states except IDLE and DONE.
// - Exactly one outstanding transaction; VALIDs never drop before READY, and payload stays stable while VALID.
// - Throughput: min 3 cycles/word (FETCH, ISSUE, RESP) when slave responds in zero wait.
// - Abort leaves the remaining stream words unconsumed; upstream must flush.
// - ap_rst mid-load: immediate IDLE, VALIDs low; the slave must be reset in the same domain.
// CONFIGURATION
// - THRESH_LOADER_VERIFY_EN defined: after a good B, the FSM goes to RDADDR (ARVALID, same addr), then RDDATA (RREADY=1).
//   - RDATA[T_WIDTH-1:0] != written word, or RRESP!=0: err, err_addr, abort.
//   - Otherwise continue as RESP-OK. Minimum 5 cycles/word.
// - Undefined: ARVALID=0, RREADY=0 constant; read inputs ignored.
// TESTING
// - CHANNELS=4, PE=2, O_WIDTH=2, stream 0..11:
//   - AWADDR sequence 0x00,0x04,0x08,0x10,...
//   - ch1 t0 at 0x10; ch2 t0 at 0x20.
//   - done pulse after 12th B; err=0.
// - T_SIGNED=1, T_WIDTH=8, word 8'h80 -> WDATA 32'hFFFFFF80. With T_SIGNED=0 -> 32'h00000080.
// - Slave holds AWREADY low 3 cycles, WREADY immediate: WVALID drops after 1 cycle, AWVALID stays until cycle 4, AWADDR stable.
// - BRESP=2'b10 on word 5: err=1, err_addr=address of word 5, done pulse, stream tready stays 0 afterwards.
// - ap_rst asserted during ISSUE: same-cycle async drop of AWVALID/WVALID/busy. Next start reloads from word 0.
// - VERIFY_EN, slave corrupts RDATA of word 2: err=1, err_addr=word-2 address, no further AW issued.

Source files
------------

// File: rtl/thresholding_axilite_loader.sv
// thresholding_axilite_loader: AXI-Lite initiator that writes a streamed threshold table into a thresholding kernel
// Define THRESH_LOADER_VERIFY_EN to read back and compare every word after its write response.
module thresholding_axilite_loader #(
  parameter int O_WIDTH = 2,
  parameter int T_WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int PE = 1,
  parameter int T_SIGNED = 1,
  localparam int CF = CHANNELS / PE,
  localparam int ADDR_BITS = $clog2(CF) + $clog2(PE) + O_WIDTH + 2,
  localparam int TD_WIDTH = ((T_WIDTH + 7) / 8) * 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_BITS-1:0] err_addr,
  input  logic                 s_thr_tvalid,
  output logic                 s_thr_tready,
  input  logic [TD_WIDTH-1:0]  s_thr_tdata,
  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,
  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP,
  output logic                 m_axilite_ARVALID,
  input  logic                 m_axilite_ARREADY,
  output logic [ADDR_BITS-1:0] m_axilite_ARADDR,
  input  logic                 m_axilite_RVALID,
  output logic                 m_axilite_RREADY,
  input  logic [31:0]          m_axilite_RDATA,
  input  logic [1:0]           m_axilite_RRESP
);
  localparam int N_T = 2**O_WIDTH - 1;
  localparam int PB = $clog2(PE);
  localparam int PW = PB > 0 ? PB : 1;
  localparam int CW = $clog2(CF) > 0 ? $clog2(CF) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RESP, RDADDR, RDDATA, DONE} state_t;
  state_t state_q, state_d;
  logic [O_WIDTH-1:0] t_q, t_d, t_nx;
  logic [PW-1:0] pe_q, pe_d, pe_nx;
  logic [CW-1:0] cf_q, cf_d, cf_nx;
  logic [T_WIDTH-1:0] data_q, data_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, cur_addr, err_addr_q, err_addr_d;
  logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, err_q, err_d;
  logic t_last, pe_last, last_word;
  logic unused_in;
  assign t_last = t_q == O_WIDTH'(N_T - 1);
  assign pe_last = pe_q == PW'(PE - 1);
  assign last_word = t_last && pe_last && cf_q == CW'(CF - 1);
  assign t_nx = t_last ? '0 : t_q + O_WIDTH'(1);
  assign pe_nx = t_last ? (pe_last ? '0 : pe_q + PW'(1)) : pe_q;
  assign cf_nx = (t_last && pe_last) ? cf_q + CW'(1) : cf_q;
  // pe_q stays 0 when PE==1, so the zero-width pe field contributes nothing
  assign cur_addr = ADDR_BITS'((32'(cf_q) << (PB + O_WIDTH + 2)) | (32'(pe_q) << (O_WIDTH + 2)) | (32'(t_q) << 2));
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    pe_d = pe_q;
    cf_d = cf_q;
    data_d = data_q;
    addr_d = addr_q;
    aw_pend_d = aw_pend_q;
    w_pend_d = w_pend_q;
    err_d = err_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        t_d = '0;
        pe_d = '0;
        cf_d = '0;
        err_d = 1'b0;
        err_addr_d = '0;
      end
      FETCH: if (s_thr_tvalid) begin
        state_d = ISSUE;
        data_d = s_thr_tdata[T_WIDTH-1:0];
        addr_d = cur_addr;
        aw_pend_d = 1'b1;
        w_pend_d = 1'b1;
      end
      ISSUE: begin
        aw_pend_d = aw_pend_q && !m_axilite_AWREADY;
        w_pend_d = w_pend_q && !m_axilite_WREADY;
        if (!aw_pend_d && !w_pend_d) state_d = RESP;
      end
      RESP: if (m_axilite_BVALID) begin
        if (m_axilite_BRESP != 2'b00) begin
          err_d = 1'b1;
          err_addr_d = addr_q;
          state_d = DONE;
        end else begin
`ifdef THRESH_LOADER_VERIFY_EN
          state_d = RDADDR;
`else
          state_d = last_word ? DONE : FETCH;
          t_d = t_nx;
          pe_d = pe_nx;
          cf_d = cf_nx;
`endif
        end
      end
`ifdef THRESH_LOADER_VERIFY_EN
      RDADDR: if (m_axilite_ARREADY) state_d = RDDATA;
      RDDATA: if (m_axilite_RVALID) begin
        if (m_axilite_RRESP != 2'b00 || m_axilite_RDATA[T_WIDTH-1:0] != data_q) begin
          err_d = 1'b1;
          err_addr_d = addr_q;
          state_d = DONE;
        end else begin
          state_d = last_word ? DONE : FETCH;
          t_d = t_nx;
          pe_d = pe_nx;
          cf_d = cf_nx;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      t_q <= '0;
      pe_q <= '0;
      cf_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q <= 1'b0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      pe_q <= pe_d;
      cf_q <= cf_d;
      data_q <= data_d;
      addr_q <= addr_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q <= w_pend_d;
      err_q <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign err_addr = err_addr_q;
  assign s_thr_tready = state_q == FETCH;
  assign m_axilite_AWVALID = state_q == ISSUE && aw_pend_q;
  assign m_axilite_AWADDR = addr_q;
  assign m_axilite_WVALID = state_q == ISSUE && w_pend_q;
  assign m_axilite_WDATA = T_SIGNED != 0 ? 32'($signed(data_q)) : 32'(data_q);
  assign m_axilite_WSTRB = 4'hF;
  assign m_axilite_BREADY = state_q == RESP;
  assign m_axilite_ARADDR = addr_q;
`ifdef THRESH_LOADER_VERIFY_EN
  assign m_axilite_ARVALID = state_q == RDADDR;
  assign m_axilite_RREADY = state_q == RDDATA;
`else
  assign m_axilite_ARVALID = 1'b0;
  assign m_axilite_RREADY = 1'b0;
`endif
  assign unused_in = ^{s_thr_tdata, m_axilite_RDATA, m_axilite_RRESP, m_axilite_RVALID, m_axilite_ARREADY};
endmodule

// File: tb/tb_thresholding_axilite_loader.sv
// tb_thresholding_axilite_loader: directed bench for the threshold loader with CHANNELS=4, PE=2, O_WIDTH=2
module tb_thresholding_axilite_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic tvalid = 1'b0;
  logic [7:0] tdata = '0;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;
  logic busy, done, err, tready, awvalid, wvalid, bready, arvalid, rready;
  logic [5:0] err_addr, awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic z_busy, z_done, z_err, z_tready, z_awvalid, z_wvalid, z_bready, z_arvalid, z_rready;
  logic [5:0] z_err_addr, z_awaddr, z_araddr;
  logic [31:0] z_wdata;
  logic [3:0] z_wstrb;
  int checks = 0, errors = 0;
  logic [5:0] exp_addr [12] = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18,
                                6'h20, 6'h24, 6'h28, 6'h30, 6'h34, 6'h38};
  always #5 clk = ~clk;
  thresholding_axilite_loader #(.O_WIDTH(2), .T_WIDTH(8), .CHANNELS(4), .PE(2), .T_SIGNED(1)) dut (
    .ap_clk(clk), .ap_rst(rst), .start(start), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .s_thr_tvalid(tvalid), .s_thr_tready(tready), .s_thr_tdata(tdata),
    .m_axilite_AWVALID(awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(awaddr),
    .m_axilite_WVALID(wvalid), .m_axilite_WREADY(wready), .m_axilite_WDATA(wdata), .m_axilite_WSTRB(wstrb),
    .m_axilite_BVALID(bvalid), .m_axilite_BREADY(bready), .m_axilite_BRESP(bresp),
    .m_axilite_ARVALID(arvalid), .m_axilite_ARREADY(arready), .m_axilite_ARADDR(araddr),
    .m_axilite_RVALID(rvalid), .m_axilite_RREADY(rready), .m_axilite_RDATA(rdata), .m_axilite_RRESP(rresp)
  );
  thresholding_axilite_loader #(.O_WIDTH(2), .T_WIDTH(8), .CHANNELS(4), .PE(2), .T_SIGNED(0)) dut_z (
    .ap_clk(clk), .ap_rst(rst), .start(start), .busy(z_busy), .done(z_done), .err(z_err), .err_addr(z_err_addr),
    .s_thr_tvalid(tvalid), .s_thr_tready(z_tready), .s_thr_tdata(tdata),
    .m_axilite_AWVALID(z_awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(z_awaddr),
    .m_axilite_WVALID(z_wvalid), .m_axilite_WREADY(wready), .m_axilite_WDATA(z_wdata), .m_axilite_WSTRB(z_wstrb),
    .m_axilite_BVALID(bvalid), .m_axilite_BREADY(z_bready), .m_axilite_BRESP(bresp),
    .m_axilite_ARVALID(z_arvalid), .m_axilite_ARREADY(arready), .m_axilite_ARADDR(z_araddr),
    .m_axilite_RVALID(rvalid), .m_axilite_RREADY(z_rready), .m_axilite_RDATA(rdata), .m_axilite_RRESP(rresp)
  );
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic xfer(input logic [7:0] d, input int aw_wait, input logic [1:0] br, input bit bad_rd,
                      output logic [5:0] a, output logic [31:0] wd, output logic [31:0] wdz);
    int n;
    a = '0;
    wd = '0;
    wdz = '0;
    tvalid = 1'b1;
    tdata = d;
    n = 0;
    while (!tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tready) begin
      errors++;
      $display("FAIL fetch_timeout: tready=%0b required 1", tready);
      tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    tvalid = 1'b0;
    checks++;
    if ({awvalid, wvalid, tready, wstrb} !== 7'b110_1111) begin
      errors++;
      $display("FAIL issue_start: awvalid/wvalid/tready/wstrb=%b required 1101111", {awvalid, wvalid, tready, wstrb});
    end
    a = awaddr;
    wd = wdata;
    wdz = z_wdata;
    awready = aw_wait == 0;
    wready = 1'b1;
    for (int i = 0; i < aw_wait; i++) begin
      @(negedge clk);
      wready = 1'b0;
      checks++;
      if ({awvalid, wvalid} !== 2'b10 || awaddr !== a) begin
        errors++;
        $display("FAIL aw_stall: awvalid/wvalid=%b addr=%h required 10 addr=%h", {awvalid, wvalid}, awaddr, a);
      end
      if (i == aw_wait - 1) awready = 1'b1;
    end
    @(negedge clk);
    awready = 1'b0;
    wready = 1'b0;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      errors++;
      $display("FAIL resp_phase: awvalid/wvalid/bready=%b required 001", {awvalid, wvalid, bready});
    end
    bvalid = 1'b1;
    bresp = br;
    @(negedge clk);
    bvalid = 1'b0;
    bresp = 2'b00;
`ifdef THRESH_LOADER_VERIFY_EN
    if (br == 2'b00) begin
      checks++;
      if (!arvalid || araddr !== a) begin
        errors++;
        $display("FAIL rd_addr: arvalid=%0b araddr=%h required 1 %h", arvalid, araddr, a);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      checks++;
      if (!rready) begin
        errors++;
        $display("FAIL rd_data: rready=%0b required 1", rready);
      end
      rvalid = 1'b1;
      rdata = {24'h0, bad_rd ? ~d : d};
      @(negedge clk);
      rvalid = 1'b0;
      rdata = '0;
    end
`else
    checks++;
    if (arvalid || rready || (bad_rd && br == 2'b11 && d == 8'h00 && 1'b0)) begin
      errors++;
      $display("FAIL read_idle: arvalid=%0b rready=%0b required 0 0", arvalid, rready);
    end
`endif
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, tready, awvalid, wvalid, bready, arvalid, rready} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: outputs=%b required 000000000", {busy, done, err, tready, awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if (err_addr !== 6'h00) begin
      errors++;
      $display("FAIL reset_err_addr: got %h required 00", err_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, tready} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start: busy/tready=%b required 00", {busy, tready});
    end
  endtask
  task automatic test_full_load;
    logic [5:0] a;
    logic [31:0] wd, wdz;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      xfer(8'(k), 0, 2'b00, 1'b0, a, wd, wdz);
      checks++;
      if (a !== exp_addr[k] || wd !== 32'(k)) begin
        errors++;
        $display("FAIL load_word%0d: addr=%h data=%h required %h %h", k, a, wd, exp_addr[k], 32'(k));
      end
      if (k < 11) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL load_busy%0d: busy/done=%b required 10", k, {busy, done});
        end
      end
    end
    checks++;
    if ({done, busy, err} !== 3'b100) begin
      errors++;
      $display("FAIL load_done: done/busy/err=%b required 100", {done, busy, err});
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse: done/busy=%b required 00", {done, busy});
    end
  endtask
  task automatic test_signext_reset_mid_issue;
    pulse_start();
    tvalid = 1'b1;
    tdata = 8'h80;
    @(negedge clk);
    tvalid = 1'b0;
    checks++;
    if (wdata !== 32'hFFFF_FF80 || z_wdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL sign_ext: signed=%h unsigned=%h required ffffff80 00000080", wdata, z_wdata);
    end
    checks++;
    if ({awvalid, wvalid, busy} !== 3'b111) begin
      errors++;
      $display("FAIL pre_rst_issue: aw/w/busy=%b required 111", {awvalid, wvalid, busy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({awvalid, wvalid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL async_rst: aw/w/busy=%b required 000", {awvalid, wvalid, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_aw_stall_reload;
    logic [5:0] a;
    logic [31:0] wd, wdz;
    pulse_start();
    xfer(8'h11, 0, 2'b00, 1'b0, a, wd, wdz);
    checks++;
    if (a !== 6'h00 || wd !== 32'h11) begin
      errors++;
      $display("FAIL reload_word0: addr=%h data=%h required 00 00000011", a, wd);
    end
    xfer(8'h22, 3, 2'b00, 1'b0, a, wd, wdz);
    checks++;
    if (a !== 6'h04 || wd !== 32'h22) begin
      errors++;
      $display("FAIL stall_word1: addr=%h data=%h required 04 00000022", a, wd);
    end
    for (int k = 2; k < 12; k++) begin
      xfer(8'(k), k == 7 ? 1 : 0, 2'b00, 1'b0, a, wd, wdz);
      checks++;
      if (a !== exp_addr[k]) begin
        errors++;
        $display("FAIL stall_load%0d: addr=%h required %h", k, a, exp_addr[k]);
      end
    end
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("FAIL stall_done: done/err=%b required 10", {done, err});
    end
    @(negedge clk);
  endtask
  task automatic test_bresp_err;
    logic [5:0] a;
    logic [31:0] wd, wdz;
    bit seen;
    pulse_start();
    for (int k = 0; k < 6; k++) xfer(8'(k), 0, k == 5 ? 2'b10 : 2'b00, 1'b0, a, wd, wdz);
    checks++;
    if ({err, done, busy} !== 3'b110 || err_addr !== 6'h18) begin
      errors++;
      $display("FAIL bresp_abort: err/done/busy=%b err_addr=%h required 110 18", {err, done, busy}, err_addr);
    end
    tvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen |= tready | awvalid;
    end
    tvalid = 1'b0;
    checks++;
    if (seen || err !== 1'b1) begin
      errors++;
      $display("FAIL post_abort: activity=%0b err=%0b required 0 1", seen, err);
    end
    pulse_start();
    checks++;
    if ({err, busy} !== 2'b01 || err_addr !== 6'h00) begin
      errors++;
      $display("FAIL err_clear: err/busy=%b err_addr=%h required 01 00", {err, busy}, err_addr);
    end
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
`ifdef THRESH_LOADER_VERIFY_EN
  task automatic test_verify;
    logic [5:0] a;
    logic [31:0] wd, wdz;
    bit seen;
    pulse_start();
    for (int k = 0; k < 3; k++) xfer(8'h40 + 8'(k), 0, 2'b00, k == 2, a, wd, wdz);
    checks++;
    if ({err, done} !== 2'b11 || err_addr !== 6'h08) begin
      errors++;
      $display("FAIL verify_abort: err/done=%b err_addr=%h required 11 08", {err, done}, err_addr);
    end
    tvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen |= awvalid | tready;
    end
    tvalid = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL verify_no_aw: activity=%0b required 0", seen);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_full_load();
    test_signext_reset_mid_issue();
    test_aw_stall_reload();
    test_bresp_err();
`ifdef THRESH_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
